// File: rtl/imem_port_arbiter_if.sv
// Bundle of the fetch port, loader port and instruction-memory array signals.
// The arbiter takes the slave modport; the fetch/loader/memory side takes master.
// Widths follow the same parameters as the arbiter so both ends agree.
interface imem_port_arbiter_if #(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int SIZE             = 1024,
    parameter int ADDR_BITS        = $clog2(SIZE)
);
    // fetch port (read-only)
    logic                        f_req_valid;
    logic [WORDSIZE-1:0]         f_req_addr;
    logic                        f_req_ready;
    logic                        f_rsp_valid;
    logic [INSTRUCTION_SIZE-1:0] f_rsp_instr;
    logic                        f_rsp_err;

    // loader/debug port (read/write)
    logic                        l_req_valid;
    logic                        l_req_we;
    logic [WORDSIZE-1:0]         l_req_addr;
    logic [INSTRUCTION_SIZE-1:0] l_req_wdata;
    logic                        l_req_ready;
    logic                        l_rsp_valid;
    logic [INSTRUCTION_SIZE-1:0] l_rsp_instr;
    logic                        l_rsp_err;

    // synchronous memory array
    logic                        mem_en;
    logic                        mem_we;
    logic [ADDR_BITS-1:0]        mem_addr;
    logic [INSTRUCTION_SIZE-1:0] mem_wdata;
    logic [INSTRUCTION_SIZE-1:0] mem_rdata;

    modport slave (
        input  f_req_valid, f_req_addr,
        output f_req_ready, f_rsp_valid, f_rsp_instr, f_rsp_err,
        input  l_req_valid, l_req_we, l_req_addr, l_req_wdata,
        output l_req_ready, l_rsp_valid, l_rsp_instr, l_rsp_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output f_req_valid, f_req_addr,
        input  f_req_ready, f_rsp_valid, f_rsp_instr, f_rsp_err,
        output l_req_valid, l_req_we, l_req_addr, l_req_wdata,
        input  l_req_ready, l_rsp_valid, l_rsp_instr, l_rsp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter sharing one instruction memory between fetch (F) and loader (L).
// Latency: grant is combinational; response appears exactly one cycle after the grant.
// Backpressure: ready only to the granted requester; responses cannot be stalled.
module imem_port_arbiter #(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int SIZE             = 1024,
    parameter int ADDR_BITS        = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_port_arbiter_if.slave    bus
);

    typedef enum logic {
        SRC_F = 1'b0,
        SRC_L = 1'b1
    } src_e;

    // First byte address past the array; compared over the full address width
    // so that high address bits cannot alias back into the array.
    localparam logic [WORDSIZE-1:0] BYTE_LIMIT = WORDSIZE'(SIZE) << 2;

    src_e                  prio;
    logic                  gnt_f;
    logic                  gnt_l;
    logic                  gnt;
    logic [WORDSIZE-1:0]   sel_addr;
    logic                  fault;

    logic                  rsp_vld;
    src_e                  rsp_owner;
    logic                  rsp_write;
    logic                  rsp_fault;
    logic [INSTRUCTION_SIZE-1:0] rsp_data;

    // Grant selection and address check; requests are ignored while in reset.
    always_comb begin
        gnt_f    = rst_n & bus.f_req_valid & (~bus.l_req_valid | (prio == SRC_F));
        gnt_l    = rst_n & bus.l_req_valid & ~gnt_f;
        gnt      = gnt_f | gnt_l;
        sel_addr = gnt_l ? bus.l_req_addr : bus.f_req_addr;
        fault    = (sel_addr[1:0] != 2'b00) | (sel_addr >= BYTE_LIMIT);
    end

    // Drive the memory in the grant cycle; faulted accesses leave the array untouched.
    always_comb begin
        bus.f_req_ready = gnt_f;
        bus.l_req_ready = gnt_l;
        bus.mem_en      = gnt & ~fault;
        bus.mem_we      = gnt & ~fault & gnt_l & bus.l_req_we;
        bus.mem_addr    = sel_addr[ADDR_BITS+1:2];
        bus.mem_wdata   = bus.l_req_wdata;
    end

    // Round-robin pointer: after any grant the other requester gets priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= SRC_F;
        end else if (gnt) begin
            prio <= gnt_f ? SRC_L : SRC_F;
        end
    end

    // Remember who owns the response issued next cycle and how it must be formed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld   <= 1'b0;
            rsp_owner <= SRC_F;
            rsp_write <= 1'b0;
            rsp_fault <= 1'b0;
        end else begin
            rsp_vld <= gnt;
            if (gnt) begin
                rsp_owner <= gnt_l ? SRC_L : SRC_F;
                rsp_write <= gnt_l & bus.l_req_we;
                rsp_fault <= fault;
            end
        end
    end

    // Route the response to its owner; only a clean read returns memory data.
    always_comb begin
        rsp_data        = (rsp_vld & ~rsp_write & ~rsp_fault) ? bus.mem_rdata : '0;
        bus.f_rsp_valid = rsp_vld & (rsp_owner == SRC_F);
        bus.f_rsp_err   = rsp_vld & (rsp_owner == SRC_F) & rsp_fault;
        bus.f_rsp_instr = (rsp_owner == SRC_F) ? rsp_data : '0;
        bus.l_rsp_valid = rsp_vld & (rsp_owner == SRC_L);
        bus.l_rsp_err   = rsp_vld & (rsp_owner == SRC_L) & rsp_fault;
        bus.l_rsp_instr = (rsp_owner == SRC_L) ? rsp_data : '0;
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus randomized F/L traffic.
// A reference model (shadow memory, priority flag, response queue) predicts every cycle.
// A behavioural synchronous RAM sits on the memory side of the arbiter.
module tb_imem_port_arbiter;

    localparam int WS   = 64;
    localparam int IS   = 32;
    localparam int SIZE = 1024;
    localparam int AB   = $clog2(SIZE);

    logic clk;
    logic rst_n;

    imem_port_arbiter_if #(.WORDSIZE(WS), .INSTRUCTION_SIZE(IS), .SIZE(SIZE)) bus ();

    imem_port_arbiter #(.WORDSIZE(WS), .INSTRUCTION_SIZE(IS), .SIZE(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous memory array
    logic [IS-1:0] ram [SIZE];
    logic [IS-1:0] ram_rd;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            ram_rd <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = ram_rd;

    int checks = 0;
    int passes = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit            to_l;
        logic [IS-1:0] instr;
        bit            err;
    } exp_t;

    logic [IS-1:0] ref_mem [SIZE];
    exp_t          exp_q [$];
    bit            last_was_f = 0;  // true: L has priority on contention
    bit            mg_f = 0;
    bit            mg_l = 0;

    always @(negedge clk) begin
        exp_t          e;
        logic [63:0]   a;
        bit            flt;
        bit            wr;
        int            word;
        if (!rst_n) begin
            chk("rst_f_ready", 64'(bus.f_req_ready), 64'd0);
            chk("rst_l_ready", 64'(bus.l_req_ready), 64'd0);
            chk("rst_mem_en",  64'(bus.mem_en), 64'd0);
            chk("rst_mem_we",  64'(bus.mem_we), 64'd0);
            chk("rst_rsp", 64'({bus.f_rsp_valid, bus.f_rsp_err, bus.l_rsp_valid, bus.l_rsp_err}), 64'd0);
            chk("rst_rsp_data", 64'({bus.f_rsp_instr, bus.l_rsp_instr}), 64'd0);
            exp_q.delete();
            last_was_f = 0;
            mg_f = 0;
            mg_l = 0;
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("m_f_rsp_valid", 64'(bus.f_rsp_valid), 64'(!e.to_l));
                chk("m_l_rsp_valid", 64'(bus.l_rsp_valid), 64'(e.to_l));
                if (e.to_l) begin
                    chk("m_l_rsp_instr", 64'(bus.l_rsp_instr), 64'(e.instr));
                    chk("m_l_rsp_err",   64'(bus.l_rsp_err),   64'(e.err));
                end else begin
                    chk("m_f_rsp_instr", 64'(bus.f_rsp_instr), 64'(e.instr));
                    chk("m_f_rsp_err",   64'(bus.f_rsp_err),   64'(e.err));
                end
            end else begin
                chk("m_rsp_idle", 64'({bus.f_rsp_valid, bus.l_rsp_valid}), 64'd0);
            end
            mg_f = bus.f_req_valid && (!bus.l_req_valid || !last_was_f);
            mg_l = bus.l_req_valid && !mg_f;
            chk("m_f_ready", 64'(bus.f_req_ready), 64'(mg_f));
            chk("m_l_ready", 64'(bus.l_req_ready), 64'(mg_l));
            if (mg_f || mg_l) begin
                a    = mg_f ? bus.f_req_addr : bus.l_req_addr;
                flt  = (a % 4 != 0) || (a >= 64'(SIZE) * 4);
                wr   = mg_l && bus.l_req_we && !flt;
                word = int'(a[AB+1:2]);
                chk("m_mem_en", 64'(bus.mem_en), 64'(!flt));
                chk("m_mem_we", 64'(bus.mem_we), 64'(wr));
                if (!flt) chk("m_mem_addr", 64'(bus.mem_addr), a / 4);
                if (wr)   chk("m_mem_wdata", 64'(bus.mem_wdata), 64'(bus.l_req_wdata));
                e.to_l  = mg_l;
                e.err   = flt;
                e.instr = (flt || wr) ? '0 : ref_mem[word];
                exp_q.push_back(e);
                if (wr) ref_mem[word] = bus.l_req_wdata;
                last_was_f = mg_f;
            end else begin
                chk("m_mem_en_idle", 64'(bus.mem_en), 64'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_f(input bit v, input logic [63:0] a);
        bus.f_req_valid = v;
        bus.f_req_addr  = a;
    endtask

    task automatic drive_l(input bit v, input bit we, input logic [63:0] a, input logic [31:0] d);
        bus.l_req_valid = v;
        bus.l_req_we    = we;
        bus.l_req_addr  = a;
        bus.l_req_wdata = d;
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return {62'($urandom), 2'($urandom_range(1, 3))};
        if (r == 1) return 64'(SIZE * 4) + 64'($urandom_range(0, 255)) * 4;
        if (r == 2) return {32'($urandom_range(1, 255)), 32'($urandom_range(0, 63) * 4)};
        if (r == 3) return 64'(SIZE * 4 - 4);
        return 64'($urandom_range(0, 31)) * 4;
    endfunction

    function automatic logic [31:0] stream_word(input int i);
        return (i == 5) ? 32'h00A00093 : 32'hC0DE0000 + 32'(i);
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        bit            f_pend;
        bit            l_pend;
        logic [63:0]   fa;
        logic [63:0]   la;
        bit            lwe;
        logic [31:0]   lwd;

        rst_n = 1'b0;
        drive_f(0, '0);
        drive_l(0, 0, '0, '0);
        for (int i = 0; i < SIZE; i++) begin
            ram[i]     = (i < 16) ? stream_word(i) : $urandom;
            ref_mem[i] = ram[i];
        end
        ram_rd = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_f_rsp_valid", 64'(bus.f_rsp_valid), 64'd0);
        chk("reset_mem_en", 64'(bus.mem_en), 64'd0);

        // Contention right after reset: F,L,F,L with L reading
        tick();
        rst_n = 1'b1;
        drive_f(1, 64'h0);
        drive_l(1, 0, 64'h8, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            chk("rr_f_ready", 64'(bus.f_req_ready), 64'(k % 2 == 0));
            chk("rr_l_ready", 64'(bus.l_req_ready), 64'(k % 2 == 1));
            if (k > 0) begin
                chk("rr_f_rsp", 64'(bus.f_rsp_valid), 64'(k % 2 == 1));
                chk("rr_l_rsp", 64'(bus.l_rsp_valid), 64'(k % 2 == 0));
            end
        end
        tick();
        drive_f(0, '0);
        drive_l(0, 0, '0, '0);
        @(negedge clk);
        chk("rr_last_l_rsp", 64'(bus.l_rsp_valid), 64'd1);
        chk("rr_last_l_data", 64'(bus.l_rsp_instr), 64'(stream_word(2)));

        // Single fetch of word 5
        tick();
        drive_f(1, 64'h14);
        @(negedge clk);
        chk("fetch_mem_addr", 64'(bus.mem_addr), 64'd5);
        chk("fetch_mem_en", 64'(bus.mem_en), 64'd1);
        tick();
        drive_f(0, '0);
        @(negedge clk);
        chk("fetch_rsp_valid", 64'(bus.f_rsp_valid), 64'd1);
        chk("fetch_rsp_instr", 64'(bus.f_rsp_instr), 64'h00A00093);
        chk("fetch_l_quiet", 64'(bus.l_rsp_valid), 64'd0);

        // L write followed immediately by F read of the same word
        tick();
        drive_l(1, 1, 64'h40, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_mem_we", 64'(bus.mem_we), 64'd1);
        chk("wr_mem_addr", 64'(bus.mem_addr), 64'd16);
        tick();
        drive_l(0, 0, '0, '0);
        drive_f(1, 64'h40);
        @(negedge clk);
        chk("wr_l_rsp_valid", 64'(bus.l_rsp_valid), 64'd1);
        chk("wr_l_rsp_instr", 64'(bus.l_rsp_instr), 64'd0);
        tick();
        drive_f(0, '0);
        @(negedge clk);
        chk("raw_f_rsp_instr", 64'(bus.f_rsp_instr), 64'hDEADBEEF);

        // Faults: misaligned fetch, out-of-range loader write that would alias word 0
        tick();
        drive_f(1, 64'h2);
        @(negedge clk);
        chk("flt_f_ready", 64'(bus.f_req_ready), 64'd1);
        chk("flt_f_mem_en", 64'(bus.mem_en), 64'd0);
        tick();
        drive_f(0, '0);
        drive_l(1, 1, 64'h1000, 32'hBAD0BAD0);
        @(negedge clk);
        chk("flt_f_err", 64'(bus.f_rsp_err), 64'd1);
        chk("flt_f_instr", 64'(bus.f_rsp_instr), 64'd0);
        chk("flt_l_mem_en", 64'(bus.mem_en), 64'd0);
        tick();
        drive_l(0, 0, '0, '0);
        @(negedge clk);
        chk("flt_l_valid", 64'(bus.l_rsp_valid), 64'd1);
        chk("flt_l_err", 64'(bus.l_rsp_err), 64'd1);
        chk("flt_l_instr", 64'(bus.l_rsp_instr), 64'd0);
        chk("flt_word0", 64'(ram[0]), 64'hC0DE0000);

        // Back-to-back streaming of words 0..15
        for (int i = 0; i < 16; i++) begin
            tick();
            drive_f(1, 64'(i * 4));
            @(negedge clk);
            chk("stream_ready", 64'(bus.f_req_ready), 64'd1);
            if (i > 0) begin
                chk("stream_valid", 64'(bus.f_rsp_valid), 64'd1);
                chk("stream_instr", 64'(bus.f_rsp_instr), 64'(stream_word(i - 1)));
            end
        end
        tick();
        drive_f(0, '0);
        @(negedge clk);
        chk("stream_last", 64'(bus.f_rsp_instr), 64'(stream_word(15)));

        // Reset while an F grant is waiting for its response
        tick();
        drive_f(1, 64'h8);
        @(negedge clk);
        chk("mid_grant", 64'(bus.f_req_ready), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(bus.f_req_ready), 64'd0);
        chk("mid_rst_mem_en", 64'(bus.mem_en), 64'd0);
        tick();
        chk("mid_rst_no_rsp", 64'(bus.f_rsp_valid), 64'd0);
        drive_f(0, '0);
        tick();
        rst_n = 1'b1;
        drive_f(1, 64'h0);
        drive_l(1, 0, 64'h4, '0);
        @(negedge clk);
        chk("post_rst_f_first", 64'(bus.f_req_ready), 64'd1);
        chk("post_rst_no_stale", 64'({bus.f_rsp_valid, bus.l_rsp_valid}), 64'd0);
        tick();
        drive_f(0, '0);
        drive_l(0, 0, '0, '0);

        // Randomized traffic; a request is held until the model says it was granted
        f_pend = 0;
        l_pend = 0;
        fa = '0; la = '0; lwe = 0; lwd = '0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (f_pend && mg_f) f_pend = 0;
            if (l_pend && mg_l) l_pend = 0;
            if (!f_pend && ($urandom_range(0, 2) != 0)) begin
                f_pend = 1;
                fa = rand_addr();
            end
            if (!l_pend && ($urandom_range(0, 2) != 0)) begin
                l_pend = 1;
                la  = rand_addr();
                lwe = 1'($urandom);
                lwd = $urandom;
            end
            drive_f(f_pend, fa);
            drive_l(l_pend, lwe, la, lwd);
        end
        tick();
        drive_f(0, '0);
        drive_l(0, 0, '0, '0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
